// File: rtl/psum_accum_wb.sv
// psum_accum_wb: accumulates PE group sums across input-channel passes, then on the
// final pass adds bias, round-shift requantises to int8 and issues ofmap writes.
// Optional macro PSUM_RELU_EN: negative results are clamped to 0 before saturation.
module psum_accum_wb #(
  parameter int ACC_W  = 24,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        layer,
  input  logic              start,
  input  logic [ADDR_W:0]   num_pix,
  input  logic [3:0]        num_pass,
  input  logic [15:0]       bias1,
  input  logic [15:0]       bias2,
  input  logic [4:0]        shamt,
  input  logic              gs_valid,
  input  logic [18:0]       groupsum_in1,
  input  logic [18:0]       groupsum_in2,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [1:0]        wr_be,
  output logic              sat_flag
);

  localparam logic [3:0] LAYER5 = 4'd5;
  localparam int S_W = ACC_W + 1;
  localparam int R_W = ACC_W + 2;
  localparam logic signed [S_W-1:0] ACC_MAX = S_W'((longint'(1) <<< (ACC_W - 1)) - 1);
  localparam logic signed [S_W-1:0] ACC_MIN = S_W'(-(longint'(1) <<< (ACC_W - 1)));
  localparam logic signed [R_W-1:0] Q_MAX   = R_W'(127);
  localparam logic signed [R_W-1:0] Q_MIN   = R_W'(-128);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                dual_q, dual_d;
  logic [ADDR_W:0]     num_pix_q, num_pix_d;
  logic [3:0]          num_pass_q, num_pass_d;
  logic [15:0]         bias1_q, bias1_d, bias2_q, bias2_d;
  logic [4:0]          shamt_q, shamt_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [3:0]          pass_cnt_q, pass_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic signed [S_W-1:0] s1_sum1_q, s1_sum1_d, s1_sum2_q, s1_sum2_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic [1:0]          wr_be_q, wr_be_d;

  logic signed [ACC_W-1:0] psum1_mem [DEPTH];
  logic signed [ACC_W-1:0] psum2_mem [DEPTH];
  logic                    mem_we;
  logic [ACC_W-1:0]        mem_wd1, mem_wd2;

  logic                  first_pass, final_pass, last_pix;
  logic signed [S_W-1:0] g1, g2, rd1, rd2, acc_sum1, acc_sum2;
  logic                  ovf1, ovf2;
  logic [8:0]            q1, q2;

  function automatic logic [ACC_W-1:0] clamp_acc(input logic signed [S_W-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  // Returns {saturated, int8}; rounding adds half an LSB of the shifted result.
  function automatic logic [8:0] requant(input logic signed [S_W-1:0] s,
                                         input logic [4:0] sh);
    logic signed [R_W-1:0] rnd;
    logic signed [R_W-1:0] r;
    rnd = (sh == 5'd0) ? '0 : (R_W'(1) <<< (sh - 5'd1));
    r   = (R_W'(s) + rnd) >>> sh;
`ifdef PSUM_RELU_EN
    if (r < 0) r = '0;
`endif
    if (r > Q_MAX)      return {1'b1, 8'h7f};
    else if (r < Q_MIN) return {1'b1, 8'h80};
    else                return {1'b0, r[7:0]};
  endfunction

  always_comb begin
    first_pass = (pass_cnt_q == 4'd0);
    final_pass = (pass_cnt_q == num_pass_q - 4'd1);
    last_pix   = ({1'b0, pix_cnt_q} == num_pix_q - 1'b1);

    g1  = S_W'(signed'(groupsum_in1));
    g2  = dual_q ? S_W'(signed'(groupsum_in2)) : '0;
    // Pass 0 ignores stale buffer contents, so the sum is just the sign-extended beat.
    rd1 = first_pass ? '0 : S_W'(psum1_mem[pix_cnt_q]);
    rd2 = (first_pass || !dual_q) ? '0 : S_W'(psum2_mem[pix_cnt_q]);
    acc_sum1 = rd1 + g1;
    acc_sum2 = rd2 + g2;
    ovf1 = (acc_sum1 > ACC_MAX) || (acc_sum1 < ACC_MIN);
    ovf2 = (acc_sum2 > ACC_MAX) || (acc_sum2 < ACC_MIN);

    q1 = requant(s1_sum1_q, shamt_q);
    q2 = requant(s1_sum2_q, shamt_q);
  end

  always_comb begin
    state_d    = state_q;
    dual_d     = dual_q;
    num_pix_d  = num_pix_q;
    num_pass_d = num_pass_q;
    bias1_d    = bias1_q;
    bias2_d    = bias2_q;
    shamt_d    = shamt_q;
    pix_cnt_d  = pix_cnt_q;
    pass_cnt_d = pass_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sat_d      = sat_q;
    s1_valid_d = 1'b0;
    s1_addr_d  = s1_addr_q;
    s1_sum1_d  = s1_sum1_q;
    s1_sum2_d  = s1_sum2_q;
    mem_we     = 1'b0;
    mem_wd1    = clamp_acc(acc_sum1);
    mem_wd2    = clamp_acc(acc_sum2);

    wr_en_d   = s1_valid_q;
    wr_addr_d = s1_valid_q ? s1_addr_q : '0;
    wr_data_d = s1_valid_q ? {q2[7:0], q1[7:0]} : '0;
    wr_be_d   = s1_valid_q ? (dual_q ? 2'b11 : 2'b01) : '0;
    if (s1_valid_q && (q1[8] || q2[8])) sat_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dual_d     = (layer == LAYER5);
          num_pix_d  = num_pix;
          num_pass_d = (num_pass == 4'd0) ? 4'd1 : num_pass;
          bias1_d    = bias1;
          bias2_d    = (layer == LAYER5) ? bias2 : '0;
          shamt_d    = shamt;
          pix_cnt_d  = '0;
          pass_cnt_d = '0;
          sat_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = (num_pix == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (gs_valid) begin
          if (final_pass) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = pix_cnt_q;
            s1_sum1_d  = acc_sum1 + S_W'(signed'(bias1_q));
            s1_sum2_d  = acc_sum2 + S_W'(signed'(bias2_q));
          end else begin
            mem_we = 1'b1;
            if (ovf1 || ovf2) sat_d = 1'b1;
          end
          if (last_pix) begin
            pix_cnt_d = '0;
            if (final_pass) begin
              pass_cnt_d = '0;
              state_d    = DRAIN;
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // S1 empty here means the final write issues this cycle, so done lands just after it.
        if (!s1_valid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dual_q     <= 1'b0;
      num_pix_q  <= '0;
      num_pass_q <= '0;
      bias1_q    <= '0;
      bias2_q    <= '0;
      shamt_q    <= '0;
      pix_cnt_q  <= '0;
      pass_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_sum1_q  <= '0;
      s1_sum2_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      dual_q     <= dual_d;
      num_pix_q  <= num_pix_d;
      num_pass_q <= num_pass_d;
      bias1_q    <= bias1_d;
      bias2_q    <= bias2_d;
      shamt_q    <= shamt_d;
      pix_cnt_q  <= pix_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_sum1_q  <= s1_sum1_d;
      s1_sum2_q  <= s1_sum2_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      psum1_mem[pix_cnt_q] <= mem_wd1;
      psum2_mem[pix_cnt_q] <= mem_wd2;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_be    = wr_be_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_psum_accum_wb.sv
// Bench for psum_accum_wb: directed and random tiles checked against an arithmetic model
// of accumulate / bias / round-shift / saturate, including exact write and done timing.
module tb_psum_accum_wb;
  localparam int ADDR_W = 6;
  localparam longint ACC_MAX = 8388607;
  localparam longint ACC_MIN = -8388608;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        layer = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_pix = '0;
  logic [3:0]        num_pass = '0;
  logic [15:0]       bias1 = '0, bias2 = '0;
  logic [4:0]        shamt = '0;
  logic              gs_valid = 1'b0;
  logic [18:0]       groupsum_in1 = '0, groupsum_in2 = '0;
  logic              busy, done, wr_en, sat_flag;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;

  psum_accum_wb #(.ACC_W(24), .DEPTH(64), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .layer(layer), .start(start), .num_pix(num_pix),
    .num_pass(num_pass), .bias1(bias1), .bias2(bias2), .shamt(shamt),
    .gs_valid(gs_valid), .groupsum_in1(groupsum_in1), .groupsum_in2(groupsum_in2),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int gs1 [0:15][0:63];
  int gs2 [0:15][0:63];
  bit model_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accumulate across passes with clamping, then bias, round half up, shift, clamp to int8.
  function automatic int lane_out(input int lane, input int pix, input int np,
                                  input int bias, input int sh);
    longint a, g, s, r;
    a = 0;
    r = 0;
    for (int p = 0; p < np; p++) begin
      g = (lane == 1) ? longint'(gs1[p][pix]) : longint'(gs2[p][pix]);
      if (p < np - 1) begin
        a = a + g;
        if (a > ACC_MAX) begin a = ACC_MAX; model_sat = 1'b1; end
        else if (a < ACC_MIN) begin a = ACC_MIN; model_sat = 1'b1; end
      end else begin
        s = a + g + longint'(bias);
        if (sh > 0) s = s + (longint'(1) << (sh - 1));
        r = s >>> sh;
`ifdef PSUM_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) begin r = 127; model_sat = 1'b1; end
        else if (r < -128) begin r = -128; model_sat = 1'b1; end
      end
    end
    return int'(r) & 255;
  endfunction

  function automatic logic [3:0] single_layer();
    logic [3:0] l;
    l = 4'($urandom_range(0, 15));
    if (l == 4'd5) l = 4'd1;
    return l;
  endfunction

  task automatic run_tile(input bit dual, input int npix, input int npass, input int b1,
                          input int b2, input int sh, input int gap, input bit extra_start);
    int np, k, n, last, done_idx, total;
    int pix_data [0:63];
    bit dv [0:255];
    bit dst [0:255];
    int dg1 [0:255];
    int dg2 [0:255];
    bit ew [0:255];
    int ea [0:255];
    int ed [0:255];
    np = (npass == 0) ? 1 : npass;
    model_sat = 1'b0;
    for (int x = 0; x < npix; x++)
      pix_data[x] = lane_out(1, x, np, b1, sh) | (dual ? (lane_out(2, x, np, b2, sh) << 8) : 0);
    for (int i = 0; i < 256; i++) begin
      dv[i] = 1'b0; dst[i] = 1'b0; ew[i] = 1'b0; ea[i] = 0; ed[i] = 0;
      dg1[i] = int'($urandom_range(0, 524287)) - 262144;
      dg2[i] = int'($urandom_range(0, 524287)) - 262144;
    end
    dst[0] = 1'b1;
    k = 1; n = 0; last = 0;
    for (int p = 0; p < np; p++) begin
      for (int x = 0; x < npix; x++) begin
        dv[k] = 1'b1; dg1[k] = gs1[p][x]; dg2[k] = gs2[p][x];
        if (p == np - 1) begin ew[k+2] = 1'b1; ea[k+2] = x; ed[k+2] = pix_data[x]; end
        if (extra_start && n == (npix * np) / 2) dst[k + ((gap > 0) ? 1 : 0)] = 1'b1;
        last = k; n++; k = k + 1 + gap;
      end
    end
    done_idx = (npix == 0) ? 2 : last + 3;
    total = done_idx + 3;
    // Beats outside RUN must be ignored, so scatter gs_valid there.
    dv[0] = 1'($urandom_range(0, 1));
    for (int i = last + 1; i < total; i++) dv[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(i >= 1 && i < done_idx));
      check("done", 32'(done), 32'(i == done_idx));
      check("wr_en", 32'(wr_en), 32'(ew[i]));
      if (ew[i]) begin
        check("wr_addr", 32'(wr_addr), 32'(ea[i]));
        check("wr_data", 32'(wr_data), 32'(ed[i]));
        check("wr_be", 32'(wr_be), dual ? 32'd3 : 32'd1);
      end
      if (i == 1) check("sat_clear", 32'(sat_flag), 32'd0);
      start = dst[i];
      gs_valid = dv[i];
      groupsum_in1 = 19'(dg1[i]);
      groupsum_in2 = 19'(dg2[i]);
      if (i == 0) begin
        layer = dual ? 4'd5 : single_layer();
        num_pix = 7'(npix); num_pass = 4'(npass);
        bias1 = 16'(b1); bias2 = 16'(b2); shamt = 5'(sh);
      end else begin
        layer = 4'($urandom); num_pix = 7'($urandom_range(0, 64)); num_pass = 4'($urandom);
        bias1 = 16'($urandom); bias2 = 16'($urandom); shamt = 5'($urandom_range(0, 23));
      end
    end
    check("sat_flag", 32'(sat_flag), 32'(model_sat));
  endtask

  initial begin
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_be", 32'(wr_be), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    rst = 1'b1;

    // Single lane, one pass: 5, -3, 127, 200 -> 5, FD, 7F, 7F with saturation.
    gs1[0][0] = 5; gs1[0][1] = -3; gs1[0][2] = 127; gs1[0][3] = 200;
    run_tile(1'b0, 4, 1, 0, 0, 0, 0, 1'b0);

    // Three-pass accumulation with bias 4, shift 2 -> 9 and -6.
    for (int p = 0; p < 3; p++) begin gs1[p][0] = 10; gs1[p][1] = -10; end
    run_tile(1'b0, 2, 3, 4, 0, 2, 0, 1'b0);
    // Same tile with one beat every three cycles and a stray start mid-tile.
    run_tile(1'b0, 2, 3, 4, 0, 2, 2, 1'b1);

    // Dual lane: 100 and -300 -> {80, 64}.
    gs1[0][0] = 100; gs2[0][0] = -300;
    run_tile(1'b1, 1, 1, 0, 0, 0, 0, 1'b0);

    // Empty tile and num_pass 0 treated as a single pass.
    run_tile(1'b0, 0, 1, 0, 0, 0, 0, 1'b0);
    gs1[0][0] = -77; gs1[0][1] = 1000; gs2[0][0] = 33; gs2[0][1] = -5000;
    run_tile(1'b1, 2, 0, -20, 9, 3, 0, 1'b0);

    // Reset during pass 1 aborts the tile.
    @(negedge clk);
    layer = 4'd1; start = 1'b1; num_pix = 7'd2; num_pass = 4'd3;
    bias1 = 16'd4; shamt = 5'd2; gs_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; gs_valid = 1'b1; groupsum_in1 = 19'd10;
    @(negedge clk);
    groupsum_in1 = 19'(-10);
    @(negedge clk);
    groupsum_in1 = 19'd10;
    @(negedge clk);
    gs_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_wr_en", 32'(wr_en), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    gs1[0][0] = 7;
    run_tile(1'b0, 1, 1, 0, 0, 0, 0, 1'b0);

    // Random tiles.
    for (int t = 0; t < 10; t++) begin
      int mag, npx, npa, sh, gap;
      bit d;
      mag = (t % 2 == 1) ? 262143 : 400;
      d   = 1'($urandom_range(0, 1));
      npx = int'($urandom_range(1, 6));
      npa = int'($urandom_range(0, 3));
      sh  = int'($urandom_range(0, 23));
      gap = int'($urandom_range(0, 2));
      for (int p = 0; p < 4; p++)
        for (int x = 0; x < 8; x++) begin
          gs1[p][x] = int'($urandom_range(0, 2 * mag)) - mag;
          gs2[p][x] = int'($urandom_range(0, 2 * mag)) - mag;
        end
      run_tile(d, npx, npa, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, sh, gap, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/psum_accum_wb.md
Name: psum_accum_wb

Overview:
- Post-processing stage directly downstream of the PE group.
- Consumes the per-cycle group sums (groupsum_out1/2, qualified by wb_en) and accumulates them across input-channel passes in a per-pixel partial-sum buffer.
- On the final pass, adds bias, applies round-and-shift requantisation and saturates to int8.
- Issues writes to the ofmap SRAM.

Parameters:
- ACC_W, 24, signed width of the partial-sum accumulator entries.
- DEPTH, 64, number of pixel entries in the partial-sum buffer.
- ADDR_W, 6, log2(DEPTH); width of the write address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (`RstEnable).
- layer  in  4  layer code; `Layer5 selects dual-lane mode; any other value selects single-lane (`Layer1) mode.
- start  in  1  one-cycle pulse that latches configuration and begins a tile.
- num_pix  in  ADDR_W+1  pixels per pass, 0..DEPTH.
- num_pass  in  4  passes to accumulate; 0 is treated as 1.
- bias1  in  16  signed bias, lane 1.
- bias2  in  16  signed bias, lane 2 (dual-lane mode only).
- shamt  in  5  requantisation right shift, 0..23.
- gs_valid  in  1  group-sum beat valid (driven by PE wb_en).
- groupsum_in1  in  19  signed group sum, lane 1.
- groupsum_in2  in  19  signed group sum, lane 2.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write issues.
- wr_en  out  1  ofmap write strobe.
- wr_addr  out  ADDR_W  ofmap pixel address.
- wr_data  out  16  {lane2 int8, lane1 int8}.
- wr_be  out  2  byte enables: 2'b01 in single-lane mode, 2'b11 in dual-lane mode.
- sat_flag  out  1  sticky; set on any accumulator or output saturation; cleared by start.

Behaviour:
- Reset: clk/rst as decided; reset is asynchronous, active-low.
  - All outputs reset to 0. State = IDLE; counters = 0.
  - Buffer contents need no reset, because pass 0 overwrites every entry.
  - Reset mid-tile aborts the tile; no write or done follows.
- States:
  - IDLE: start moves to RUN, latches all config and clears sat_flag. If num_pix==0, go to DRAIN instead.
  - RUN: each gs_valid beat is one pixel of the current pass.
    - pix_cnt increments and wraps at num_pix-1; on wrap, pass_cnt increments.
    - After the final beat of the final pass, go to DRAIN.
  - DRAIN: wait until the output pipeline is empty, pulse done, return to IDLE.
  - DONE pulse: done is asserted for exactly one cycle; busy falls in the same cycle.
- Ignored inputs: start while busy; gs_valid in IDLE or DRAIN.
- Lane handling:
  - Single-lane mode uses groupsum_in1 only; lane 2 is held at 0.
  - Dual-lane mode uses both lanes, each with its own buffer entry.
- Accumulation (per lane):
  - Pass 0: entry = sign-extend(groupsum).
  - Later passes: entry = entry + groupsum, saturating at ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)); saturation sets sat_flag.
- Final pass datapath: the buffer is not written. Two-stage pipeline:
  - S1: s = acc + groupsum + sign-extend(bias), computed at ACC_W+1 bits.
  - S2: r = (s + (shamt ? 1<<(shamt-1) : 0)) >>> shamt. Saturate r to [-128,127]; saturation sets sat_flag.
  - S2 drives wr_en/wr_addr/wr_data/wr_be.
- Latency: a final-pass gs_valid in cycle t produces wr_en in cycle t+2, with wr_addr = pix_cnt value at t. done is asserted at t+3 for the last beat.
- Write rate: back-to-back gs_valid beats produce back-to-back writes. No backpressure exists; the SRAM always accepts.
- num_pass==1: every beat is a final-pass beat; the buffer is never read.
- num_pix==0: done pulses 2 cycles after start; no writes.

Optional Feature:
- Macro: PSUM_RELU_EN.
- Defined: a ReLU is applied in S2 before saturation (r<0 gives 0), so output range is [0,127].
- Not defined: signed output range [-128,127] with no clamping of negatives.

Test Plan:
- Single-lane, num_pix=4, num_pass=1, bias1=0, shamt=0, sums 5,-3,127,200:
  - writes at addr 0..3 with data 5, 0xFD, 127, 127 (wr_be=01), each 2 cycles after its beat.
  - sat_flag=1; done one cycle after the last write.
- Accumulation, num_pix=2, num_pass=3, lane1 sums per pass {10,-10}, bias1=4, shamt=2:
  - addr0 = (30+4+2)>>2 = 9; addr1 = (-30+4+2)>>>2 = -6 (0xFA).
  - No writes during passes 0 and 1.
- Dual-lane (`Layer5), num_pix=1, num_pass=1, in1=100, in2=-300, biases 0, shamt=0:
  - wr_data = {8'h80, 8'h64}, wr_be=11, sat_flag=1.
- PSUM_RELU_EN defined, with the previous accumulation case:
  - addr1 writes 0; addr0 still writes 9.
- Gapped gs_valid (1 beat every 3 cycles) plus a start pulse mid-tile:
  - outputs identical to the gapless run; the extra start is ignored.
- rst asserted during pass 1, then released:
  - all outputs 0, no done.
  - A new tile with num_pass=1, sum 7 writes 7 at addr 0.
